// File: rtl/theremin_sensor_pkg.sv
// Shared types and helpers for the theremin sensor chain.
// Contents:
//   period_avg_state_t : averaging FSM states (IDLE, FILL, RUN)
//   sum_width()        : width of a sum of 2^avg_log2 values of counter_bits each
package theremin_sensor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } period_avg_state_t;

  // A sum of 2^avg_log2 unsigned terms needs exactly avg_log2 extra bits.
  function automatic int sum_width(input int counter_bits, input int avg_log2);
    return counter_bits + avg_log2;
  endfunction

endpackage

// File: rtl/period_ring_buffer.sv
// Window storage for period_moving_sum.
// Ports:
//   CLK     : system clock
//   wr_en   : write wr_data into entry ptr on the rising edge
//   ptr     : entry being read and (optionally) written this cycle
//   wr_data : new measurement
//   rd_data : current content of entry ptr (combinational), i.e. the value
//             about to be overwritten when wr_en is high
// Storage is not reset: the fill logic never reads an entry before writing it.
module period_ring_buffer #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                 CLK,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] ptr,
  input  logic [WIDTH-1:0]     wr_data,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

  assign rd_data = mem[ptr];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/period_moving_sum.sv
// Moving sum of the last 2^AVG_LOG2 half-period measurements.
// Ports:
//   CLK          : 100MHz system clock
//   RESET        : asynchronous, active-high reset
//   EDGE_FLAG    : new-measurement flag; its rising edge marks a new DURATION
//   DURATION     : measured half-period, sampled on the EDGE_FLAG rise
//   PERIOD_SUM   : registered sum of the last DEPTH durations
//   PERIOD_VALID : one-cycle strobe, PERIOD_SUM updated this cycle
//   SIGNAL_OK    : high while a full window is being tracked
//
// state | meaning
// IDLE  | no signal; the next edge is discarded (its duration spans the gap)
// FILL  | collecting the first DEPTH durations, no output strobes
// RUN   | window full; each edge slides the window and strobes PERIOD_SUM
module period_moving_sum
  import theremin_sensor_pkg::*;
#(
  parameter int COUNTER_BITS   = 16,
  parameter int AVG_LOG2       = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                                         CLK,
  input  logic                                         RESET,
  input  logic                                         EDGE_FLAG,
  input  logic [COUNTER_BITS-1:0]                      DURATION,
  output logic [sum_width(COUNTER_BITS, AVG_LOG2)-1:0] PERIOD_SUM,
  output logic                                         PERIOD_VALID,
  output logic                                         SIGNAL_OK
);

  localparam int SW    = sum_width(COUNTER_BITS, AVG_LOG2);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TW-1:0]     TO_LIMIT  = TW'(TIMEOUT_CYCLES);
  localparam logic [AVG_LOG2:0] FILL_LAST = (AVG_LOG2 + 1)'(DEPTH - 1);

  period_avg_state_t state_q, state_d;

  logic                    edge_q;
  logic [AVG_LOG2-1:0]     ptr_q, ptr_d;
  logic [AVG_LOG2:0]       fill_q, fill_d;
  logic [TW-1:0]           to_cnt_q, to_cnt_d;
  logic [SW-1:0]           acc_q, acc_d;
  logic [SW-1:0]           sum_q, sum_d;
  logic                    valid_q, valid_d;

  logic                    edge_det;
  logic                    dur_sat;
  logic                    timed_out;
  logic                    wr_en;
  logic [COUNTER_BITS-1:0] rd_data;

  period_ring_buffer #(
    .WIDTH    (COUNTER_BITS),
    .ADDR_BITS(AVG_LOG2)
  ) u_ring (
    .CLK    (CLK),
    .wr_en  (wr_en),
    .ptr    (ptr_q),
    .wr_data(DURATION),
    .rd_data(rd_data)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      edge_q   <= 1'b0;
      ptr_q    <= '0;
      fill_q   <= '0;
      to_cnt_q <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      edge_q   <= EDGE_FLAG;
      ptr_q    <= ptr_d;
      fill_q   <= fill_d;
      to_cnt_q <= to_cnt_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    edge_det  = EDGE_FLAG & ~edge_q;
    dur_sat   = &DURATION;
    timed_out = (to_cnt_q == TO_LIMIT);

    state_d = state_q;
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    valid_d = 1'b0;
    wr_en   = 1'b0;

    // Saturates at the limit so it cannot wrap during long silences in IDLE.
    if (edge_det) begin
      to_cnt_d = '0;
    end else if (timed_out) begin
      to_cnt_d = to_cnt_q;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    // An edge always takes priority over a timeout in the same cycle.
    case (state_q)
      IDLE: begin
        if (edge_det && !dur_sat) begin
          state_d = FILL;
          ptr_d   = '0;
          fill_d  = '0;
          acc_d   = '0;
        end
      end
      FILL: begin
        if (edge_det) begin
          if (dur_sat) begin
            state_d = IDLE;
          end else begin
            wr_en  = 1'b1;
            acc_d  = acc_q + SW'(DURATION);
            ptr_d  = ptr_q + 1'b1;
            fill_d = fill_q + 1'b1;
            if (fill_q == FILL_LAST) begin
              state_d = RUN;
              sum_d   = acc_d;
              valid_d = 1'b1;
            end
          end
        end else if (timed_out) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (edge_det) begin
          if (dur_sat) begin
            state_d = IDLE;
          end else begin
            // rd_data is the oldest entry, about to be replaced.
            wr_en   = 1'b1;
            acc_d   = acc_q + SW'(DURATION) - SW'(rd_data);
            ptr_d   = ptr_q + 1'b1;
            sum_d   = acc_d;
            valid_d = 1'b1;
          end
        end else if (timed_out) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign PERIOD_SUM   = sum_q;
  assign PERIOD_VALID = valid_q;
  assign SIGNAL_OK    = (state_q == RUN);

endmodule

// File: tb/tb_period_moving_sum.sv
// Self-checking bench for period_moving_sum (DEPTH=4, timeout 1000 cycles).
// A queue-based window model predicts every output after every clock edge;
// directed sequences add literal checks on the key scenarios.
module tb_period_moving_sum;

  localparam int CB    = 16;
  localparam int AL    = 2;
  localparam int DEPTH = 4;
  localparam int TO    = 1000;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          EDGE_FLAG;
  logic [CB-1:0] DURATION;
  logic [CB+AL-1:0] PERIOD_SUM;
  logic          PERIOD_VALID;
  logic          SIGNAL_OK;

  always #5 CLK = ~CLK;

  period_moving_sum #(
    .COUNTER_BITS  (CB),
    .AVG_LOG2      (AL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .EDGE_FLAG   (EDGE_FLAG),
    .DURATION    (DURATION),
    .PERIOD_SUM  (PERIOD_SUM),
    .PERIOD_VALID(PERIOD_VALID),
    .SIGNAL_OK   (SIGNAL_OK)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference model: 0 = no signal, 1 = filling, 2 = running.
  int m_mode;
  int win[$];
  int m_sum;
  bit m_valid;
  bit m_prev;
  int m_idle;

  function automatic int window_total();
    int t = 0;
    foreach (win[i]) t += win[i];
    return t;
  endfunction

  function automatic void model_reset();
    m_mode  = 0;
    win.delete();
    m_sum   = 0;
    m_valid = 0;
    m_prev  = 0;
    m_idle  = 0;
  endfunction

  function automatic void model_step(input bit flag, input int dur);
    bit rise_seen;
    rise_seen = flag && !m_prev;
    m_prev    = flag;
    m_valid   = 0;
    if (rise_seen) begin
      m_idle = 0;
      if (dur == 'hFFFF) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
        win.delete();
      end else begin
        win.push_back(dur);
        if (win.size() > DEPTH) void'(win.pop_front());
        if (win.size() == DEPTH) begin
          m_mode  = 2;
          m_sum   = window_total();
          m_valid = 1;
        end
      end
    end else begin
      if (m_mode != 0 && m_idle == TO) m_mode = 0;
      if (m_idle < TO) m_idle++;
    end
  endfunction

  task automatic drive_cycle(input bit flag, input logic [CB-1:0] dur);
    EDGE_FLAG = flag;
    DURATION  = dur;
    model_step(flag, int'(dur));
    @(posedge CLK);
    #1;
    check("period_sum", PERIOD_SUM, m_sum);
    check("period_valid", PERIOD_VALID, m_valid);
    check("signal_ok", SIGNAL_OK, m_mode == 2);
  endtask

  task automatic rise(input logic [CB-1:0] dur);
    drive_cycle(1'b1, dur);
  endtask

  task automatic fall();
    drive_cycle(1'b0, CB'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, CB'($urandom));
  endtask

  function automatic logic [CB-1:0] rand_dur();
    if ($urandom_range(0, 63) == 0) return 16'hFFFF;
    return CB'($urandom_range(0, 65534));
  endfunction

  initial begin
    RESET     = 1'b1;
    EDGE_FLAG = 1'b0;
    DURATION  = '0;
    model_reset();
    #12;
    check("reset_sum", PERIOD_SUM, 0);
    check("reset_valid", PERIOD_VALID, 0);
    check("reset_ok", SIGNAL_OK, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Fill: first edge discarded, then four stored edges.
    rise(16'd77); fall();
    rise(16'd100); fall();
    rise(16'd200); fall();
    rise(16'd300);
    check("fill_no_valid", PERIOD_VALID, 0);
    fall();
    rise(16'd400);
    check("fill_sum", PERIOD_SUM, 1000);
    check("fill_valid", PERIOD_VALID, 1);
    check("fill_ok", SIGNAL_OK, 1);
    fall();

    // Sliding window, with a 3-cycle-wide flag on the second edge.
    rise(16'd500);
    check("slide_sum_1400", PERIOD_SUM, 1400);
    fall();
    rise(16'd600);
    check("slide_sum_1800", PERIOD_SUM, 1800);
    check("slide_valid", PERIOD_VALID, 1);
    rise(16'd999);
    check("held_flag_no_valid", PERIOD_VALID, 0);
    rise(16'd999);
    check("held_flag_sum", PERIOD_SUM, 1800);
    fall();

    // Timeout in RUN.
    idle(1001);
    check("timeout_ok", SIGNAL_OK, 0);
    check("timeout_sum_held", PERIOD_SUM, 1800);
    rise(16'd123); fall();
    for (int i = 0; i < 4; i++) begin
      rise(16'd50); fall();
    end
    check("refill_sum", PERIOD_SUM, 200);
    check("refill_ok", SIGNAL_OK, 1);

    // Edge lands exactly when the counter reaches the limit.
    idle(999);
    rise(16'd60);
    check("simul_valid", PERIOD_VALID, 1);
    check("simul_ok", SIGNAL_OK, 1);
    check("simul_sum", PERIOD_SUM, 210);
    fall();

    // Saturated duration in RUN.
    rise(16'hFFFF);
    check("sat_valid", PERIOD_VALID, 0);
    check("sat_ok", SIGNAL_OK, 0);
    check("sat_sum_held", PERIOD_SUM, 210);
    fall();

    // Reset in the middle of FILL.
    rise(16'd5); fall();
    rise(16'd1000); fall();
    rise(16'd2000); fall();
    RESET = 1'b1;
    #2;
    model_reset();
    check("midreset_sum", PERIOD_SUM, 0);
    check("midreset_valid", PERIOD_VALID, 0);
    check("midreset_ok", SIGNAL_OK, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    rise(16'd9); fall();
    rise(16'd10); fall();
    rise(16'd20); fall();
    rise(16'd30); fall();
    rise(16'd40);
    check("postreset_sum", PERIOD_SUM, 100);
    check("postreset_valid", PERIOD_VALID, 1);
    fall();

    // Randomized traffic, including back-to-back edges and silences near the limit.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) idle(int'($urandom_range(995, 1005)));
      else drive_cycle(1'($urandom_range(0, 1)), rand_dur());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
